// File: rtl/call_stack.sv
// Return-address stack for a subroutine-capable controller.
// Top of stack is read combinationally; every request completes at the sampling edge.
module call_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 12,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stack_push,
  input  logic             stack_pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [PW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             stack_overflow,
  output logic             stack_underflow
);

  localparam logic [PW-1:0] SpOne  = PW'(1);
  localparam logic [PW-1:0] SpFull = PW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_sp;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_idx;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == SpFull);
  // Low bits wrap to DEPTH-1 when sp == DEPTH, which is exactly the top slot.
  assign w_top_idx = r_sp[AW-1:0] - AW'(1);
  assign w_wr_idx  = r_sp[AW-1:0];

  assign data_out        = w_empty ? '0 : r_mem[w_top_idx];
  assign count           = r_sp;
  assign empty           = w_empty;
  assign full            = w_full;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (stack_push && stack_pop) begin
      if (w_empty) begin
        r_mem[0] <= data_in;
        r_sp     <= SpOne;
      end else begin
        r_mem[w_top_idx] <= data_in;
      end
    end else if (stack_push) begin
      if (w_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_mem[w_wr_idx] <= data_in;
        r_sp            <= r_sp + SpOne;
      end
    end else if (stack_pop) begin
      if (w_empty) begin
        r_unf <= 1'b1;
      end else begin
        r_sp <= r_sp - SpOne;
      end
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: stimulus queues the expected outputs of each cycle,
// a negedge monitor pops one entry per cycle and compares the flagged ones.
module tb_call_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        stack_push;
  logic        stack_pop;
  logic [11:0] data_in;
  logic [11:0] data_out;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        stack_overflow;
  logic        stack_underflow;

  call_stack #(
    .DEPTH(8),
    .WIDTH(12)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stack_push      (stack_push),
    .stack_pop       (stack_pop),
    .data_in         (data_in),
    .data_out        (data_out),
    .count           (count),
    .empty           (empty),
    .full            (full),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk;
    logic [11:0] d;
    logic [3:0]  cnt;
    logic        emp;
    logic        ful;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Monitor: each cycle's expectation describes the outputs seen before the next edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [17:0] got, want;
      e    = q.pop_front();
      got  = {data_out, count, empty, full};
      want = {e.d, e.cnt, e.emp, e.ful};
      if (e.chk) begin
        n_vec++;
        if (got !== want || stack_overflow !== e.ov || stack_underflow !== e.un) begin
          n_bad++;
          $display("FAIL %s: got data_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b, want data_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                   e.name, data_out, count, empty, full, stack_overflow, stack_underflow,
                   e.d, e.cnt, e.emp, e.ful, e.ov, e.un);
        end
      end
    end
  end

  task automatic op(input logic p, input logic pp, input logic [11:0] din, input bit chk,
                    input string nm, input logic [11:0] d, input logic [3:0] cnt,
                    input logic ov, input logic un);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    stack_push = p;
    stack_pop  = pp;
    data_in    = din;
    e.name = nm;
    e.chk  = chk;
    e.d    = d;
    e.cnt  = cnt;
    e.emp  = (cnt == 4'd0);
    e.ful  = (cnt == 4'd8);
    e.ov   = ov;
    e.un   = un;
    q.push_back(e);
  endtask

  task automatic push(input logic [11:0] din);
    op(1'b1, 1'b0, din, 1'b0, "", 12'h0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [11:0] d, input logic [3:0] cnt,
                     input logic ov, input logic un);
    op(1'b0, 1'b0, 12'h0, 1'b1, nm, d, cnt, ov, un);
  endtask

  // Reset cycle with a push request that must be discarded.
  task automatic rst_pulse();
    exp_t e;
    @(posedge clk);
    #1;
    rst        = 1'b1;
    stack_push = 1'b1;
    stack_pop  = 1'b0;
    data_in    = 12'h7FF;
    e.name = "";
    e.chk  = 1'b0;
    e.d    = '0;
    e.cnt  = '0;
    e.emp  = 1'b0;
    e.ful  = 1'b0;
    e.ov   = 1'b0;
    e.un   = 1'b0;
    q.push_back(e);
  endtask

  initial begin
    rst        = 1'b1;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clk);

    chk("rst_state", 12'h000, 4'd0, 1'b0, 1'b0);

    // Basic LIFO order
    op(1'b1, 1'b0, 12'h00A, 1'b1, "t1_push_a_pre", 12'h000, 4'd0, 1'b0, 1'b0);
    push(12'h00B);
    push(12'h00C);
    chk("t1_three", 12'h00C, 4'd3, 1'b0, 1'b0);
    op(1'b0, 1'b1, 12'h0, 1'b1, "t1_pop_c", 12'h00C, 4'd3, 1'b0, 1'b0);
    op(1'b0, 1'b1, 12'h0, 1'b1, "t1_pop_b", 12'h00B, 4'd2, 1'b0, 1'b0);
    op(1'b0, 1'b1, 12'h0, 1'b1, "t1_pop_a", 12'h00A, 4'd1, 1'b0, 1'b0);
    chk("t1_empty", 12'h000, 4'd0, 1'b0, 1'b0);

    // Underflow is sticky, operation continues
    op(1'b0, 1'b1, 12'h0, 1'b1, "t3_pop_empty_pre", 12'h000, 4'd0, 1'b0, 1'b0);
    chk("t3_unf", 12'h000, 4'd0, 1'b0, 1'b1);
    push(12'h055);
    chk("t3_push_after", 12'h055, 4'd1, 1'b0, 1'b1);

    rst_pulse();
    chk("rst_clears_unf", 12'h000, 4'd0, 1'b0, 1'b0);

    // Replace top
    push(12'h010);
    push(12'h020);
    op(1'b1, 1'b1, 12'h0AA, 1'b1, "t4_repl_pre", 12'h020, 4'd2, 1'b0, 1'b0);
    op(1'b0, 1'b1, 12'h0, 1'b1, "t4_pop_shows_aa", 12'h0AA, 4'd2, 1'b0, 1'b0);
    chk("t4_after_pop", 12'h010, 4'd1, 1'b0, 1'b0);

    rst_pulse();
    chk("rst_mid", 12'h000, 4'd0, 1'b0, 1'b0);

    // Push+pop on empty acts as push
    op(1'b1, 1'b1, 12'h033, 1'b1, "t5_pp_empty_pre", 12'h000, 4'd0, 1'b0, 1'b0);
    chk("t5_pp_empty", 12'h033, 4'd1, 1'b0, 1'b0);

    rst_pulse();

    // Fill, overflow, then drain to five entries
    for (int i = 0; i < 8; i++) push(12'h100 + 12'(i));
    chk("t2_full", 12'h107, 4'd8, 1'b0, 1'b0);
    push(12'h1FF);
    chk("t2_ovf", 12'h107, 4'd8, 1'b1, 1'b0);
    op(1'b0, 1'b1, 12'h0, 1'b1, "t2_pop_107", 12'h107, 4'd8, 1'b1, 1'b0);
    op(1'b0, 1'b1, 12'h0, 1'b1, "t2_pop_106", 12'h106, 4'd7, 1'b1, 1'b0);
    op(1'b0, 1'b1, 12'h0, 1'b1, "t2_pop_105", 12'h105, 4'd6, 1'b1, 1'b0);
    chk("t6_five", 12'h104, 4'd5, 1'b1, 1'b0);
    rst_pulse();
    chk("t6_rst_with_push", 12'h000, 4'd0, 1'b0, 1'b0);

    // Push+pop on full replaces top, no overflow
    for (int i = 0; i < 8; i++) push(12'h200 + 12'(i));
    op(1'b1, 1'b1, 12'h2AA, 1'b1, "t5_pp_full_pre", 12'h207, 4'd8, 1'b0, 1'b0);
    chk("t5_pp_full", 12'h2AA, 4'd8, 1'b0, 1'b0);
    op(1'b0, 1'b1, 12'h0, 1'b1, "t5_pop_2aa", 12'h2AA, 4'd8, 1'b0, 1'b0);
    chk("t5_below_top", 12'h206, 4'd7, 1'b0, 1'b0);

    op(1'b0, 1'b0, 12'h0, 1'b0, "", 12'h0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
